// File: rtl/sram_like_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter_if
// Purpose  : One SRAM-like port bundle. The arbiter uses three instances:
//            the inst requester, the data requester and the shared
//            downstream port towards the SRAM-to-AXI bridge.
// Signals  : req/wr/size/wstrb/addr/wdata  request channel (master -> slave)
//            addr_ok                       request accepted (slave -> master)
//            data_ok/rdata                 response       (slave -> master)
// Modports : master - the side issuing requests
//            slave  - the side accepting requests
// Revision : 1.0 - initial release
// ============================================================================
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface
`default_nettype wire

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter
// Purpose  : Shares one downstream SRAM-like port between the instruction
//            fetch (inst) and load/store (data) requesters. The grant is
//            combinational; an in-order owner-ID FIFO routes each
//            downstream response back to the requester that issued it.
//            Up to DEPTH requests may be outstanding.
// Ports    : clk, resetn      clock, asynchronous active-low reset
//            inst  (slave)    inst requester (always a read; its
//                             wr/size/wstrb/wdata are ignored)
//            data  (slave)    data requester
//            m     (master)   shared downstream port
//            protocol_err     sticky: m.data_ok seen with nothing outstanding
// Params   : DEPTH            max outstanding requests (power of 2, >= 2)
// Macros   : ARB_ROUND_ROBIN_EN  alternate priority on conflict instead of
//                                fixed data-first priority
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  sram_like_arbiter_if.slave  inst,
  sram_like_arbiter_if.slave  data,
  sram_like_arbiter_if.master m,
  output logic                protocol_err
);

  localparam int unsigned      PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  owner_e             owner_q [DEPTH];
  owner_e             owner_d [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               perr_q, perr_d;

  logic               full;
  logic               empty;
  logic               grant_data;
  logic               push;
  logic               pop;
  owner_e             head;

  // The inst side is read-only; its write-channel fields carry no meaning.
  logic unused_inst_fields;
  assign unused_inst_fields = ^{inst.wr, inst.size, inst.wstrb, inst.wdata};

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_grant_q, last_grant_d;

  // On conflict the side that did not win the previous transfer goes first.
  assign grant_data   = data.req & (~inst.req | (last_grant_q == OWNER_INST));
  assign last_grant_d = push ? (grant_data ? OWNER_DATA : OWNER_INST) : last_grant_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= OWNER_INST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign grant_data = data.req;
`endif

  // Full blocks acceptance even if a pop happens this cycle: no bypass path.
  assign m.req = (inst.req | data.req) & ~full;
  assign push  = m.req & m.addr_ok;
  assign pop   = m.data_ok & ~empty;
  assign head  = owner_q[rptr_q];

  always_comb begin
    m.wr    = 1'b0;
    m.size  = 2'd2;
    m.wstrb = 4'b0000;
    m.addr  = inst.addr;
    m.wdata = 32'h0;
    if (grant_data) begin
      m.wr    = data.wr;
      m.size  = data.size;
      m.wstrb = data.wstrb;
      m.addr  = data.addr;
      m.wdata = data.wdata;
    end
  end

  assign inst.addr_ok = push & ~grant_data;
  assign data.addr_ok = push &  grant_data;
  assign inst.data_ok = pop & (head == OWNER_INST);
  assign data.data_ok = pop & (head == OWNER_DATA);
  assign inst.rdata   = m.rdata;
  assign data.rdata   = m.rdata;
  assign protocol_err = perr_q;

  always_comb begin
    owner_d = owner_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    perr_d  = perr_q | (m.data_ok & empty);
    if (push) begin
      owner_d[wptr_q] = grant_data ? OWNER_DATA : OWNER_INST;
      wptr_d          = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        owner_q[i] <= OWNER_INST;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      perr_q  <= perr_d;
    end
  end

endmodule
`default_nettype wire
